// File: rtl/lutram32_pkg.sv
// Shared types and sizes for the LUT-RAM arbiter and its RAM bank.
package lutram32_pkg;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef enum logic { CLEAR, IDLE } state_e;
  typedef enum logic { REQ_A, REQ_B } req_e;

  function automatic req_e other_req(input req_e r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction
endpackage

// File: rtl/lutram32_bank.sv
// 32-deep distributed RAM bank: DW single-bit primitives with shared address,
// write enable and falling-edge write; read port is combinational.
module lutram32x1
  import lutram32_pkg::*;
(
  input  logic          clk_i,
  input  logic [AW-1:0] a_i,
  input  logic          d_i,
  input  logic          we_i,
  output logic          o_o
);
  logic mem_q [DEPTH];

  // Writes land mid-cycle so a read registered on the next edge sees new data.
  always_ff @(negedge clk_i) begin
    if (we_i) mem_q[a_i] <= d_i;
  end

  assign o_o = mem_q[a_i];
endmodule

module lutram32_bank
  import lutram32_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] d_i,
  input  logic          we_i,
  output logic [DW-1:0] o_o
);
  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_bit
      lutram32x1 u_ram (
        .clk_i (clk_i),
        .a_i   (addr_i),
        .d_i   (d_i[gi]),
        .we_i  (we_i),
        .o_o   (o_o[gi])
      );
    end
  endgenerate
endmodule

// File: rtl/lutram32_arbiter.sv
// Round-robin sequencer sharing one 32-word LUT-RAM bank between requesters A and B,
// with a clear sweep after reset or on request.
module lutram32_arbiter
  import lutram32_pkg::*;
#(
  parameter int          DW       = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_req_i,
  output logic          busy_o,
  input  logic          a_valid_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic          a_ready_o,
  output logic          a_rvalid_o,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_valid_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic          b_ready_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] b_rdata_o
);
  state_e        state_q;
  req_e          rr_q;
  req_e          rd_owner_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_d_q;
  logic          ram_we_q;
  logic          rd_pend_q;
  logic          a_rvalid_q, b_rvalid_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic [DW-1:0] ram_o;
  logic          grant_a, grant_b, can_grant;

  // A clear request in the same cycle pre-empts any grant.
  assign can_grant = (state_q == IDLE) & ~clr_req_i;
  assign grant_a   = can_grant & a_valid_i & (~b_valid_i | (rr_q == REQ_A));
  assign grant_b   = can_grant & b_valid_i & (~a_valid_i | (rr_q == REQ_B));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CLEAR;
      rr_q       <= REQ_A;
      rd_owner_q <= REQ_A;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      ram_addr_q <= '0;
      ram_d_q    <= '0;
      ram_we_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      ram_we_q   <= 1'b0;

      if (rd_pend_q) begin
        if (rd_owner_q == REQ_A) begin
          a_rdata_q  <= ram_o;
          a_rvalid_q <= 1'b1;
        end else begin
          b_rdata_q  <= ram_o;
          b_rvalid_q <= 1'b1;
        end
      end

      case (state_q)
        CLEAR: begin
          ram_addr_q <= ptr_q;
          ram_d_q    <= INIT_VAL;
          ram_we_q   <= 1'b1;
          ptr_q      <= ptr_q + AW'(1);
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end else if (grant_a || grant_b) begin
            ram_addr_q <= grant_a ? a_addr_i  : b_addr_i;
            ram_d_q    <= grant_a ? a_wdata_i : b_wdata_i;
            ram_we_q   <= grant_a ? a_we_i    : b_we_i;
            rd_pend_q  <= grant_a ? ~a_we_i   : ~b_we_i;
            rd_owner_q <= grant_a ? REQ_A     : REQ_B;
            rr_q       <= other_req(grant_a ? REQ_A : REQ_B);
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  lutram32_bank #(.DW(DW)) u_bank (
    .clk_i  (clk_i),
    .addr_i (ram_addr_q),
    .d_i    (ram_d_q),
    .we_i   (ram_we_q),
    .o_o    (ram_o)
  );

  assign busy_o     = busy_q;
  assign a_ready_o  = grant_a;
  assign b_ready_o  = grant_b;
  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;
endmodule
